// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer and its control_unit
// neighbour: state encoding, the default HALT encoding and instruction fields.
package seq_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_MEM = 3'd2;
  localparam logic [2:0] ST_EXEC     = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;
  localparam logic [2:0] ST_HALTED   = 3'd5;
  localparam logic [2:0] ST_ERROR    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_FETCH    = ST_FETCH,
    S_WAIT_MEM = ST_WAIT_MEM,
    S_EXEC     = ST_EXEC,
    S_GAP      = ST_GAP,
    S_HALTED   = ST_HALTED,
    S_ERROR    = ST_ERROR
  } state_t;

  localparam logic [15:0] HALT_WORD_DEFAULT = 16'hFFFF;

  // Instruction field positions, identical to the control_unit decode
  localparam int DEST_HI = 15;
  localparam int DEST_LO = 13;
  localparam int SRC_HI  = 12;
  localparam int SRC_LO  = 10;
  localparam int ALU_HI  = 4;
  localparam int ALU_LO  = 2;

  function automatic logic [2:0] instr_dest(input logic [15:0] instr);
    return instr[DEST_HI:DEST_LO];
  endfunction

  function automatic logic [2:0] instr_src(input logic [15:0] instr);
    return instr[SRC_HI:SRC_LO];
  endfunction

  function automatic logic [2:0] instr_alu(input logic [15:0] instr);
    return instr[ALU_HI:ALU_LO];
  endfunction

endpackage

// File: rtl/instr_fetch_sequencer_watchdog.sv
// Watchdog for the control_unit handshake: counts cycles with run high and
// flags in the CU_TIMEOUT-th such cycle if no done has ended the window.
module cu_watchdog
  import seq_pkg::*;
#(
  parameter int CU_TIMEOUT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_timeout
);

  localparam int CW = $clog2(CU_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CU_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] r_cnt;

  // Run-cycle counter, restarted whenever a new instruction enters execution
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_run && !o_timeout) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign o_timeout = i_run && (r_cnt == LAST_CNT);

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: reads program words at pc, hands each one to
// the control_unit with a run/done handshake and stops on HALT, end of
// program, an external halt request or a watchdog timeout.
module instr_fetch_sequencer
  import seq_pkg::*;
#(
  parameter int          ADDR_W     = 8,
  parameter int          PROG_LEN   = 256,
  parameter logic [15:0] HALT_WORD  = HALT_WORD_DEFAULT,
  parameter int          CU_TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [15:0]       cu_instruction,
  output logic              cu_run,
  input  logic              cu_done,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       instr_count,
  output logic              busy,
  output logic              halted,
  output logic              error
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_instr;
  logic [15:0]       r_count;
  logic              r_mem_rd;
  logic              r_cu_run;
  logic              r_busy;
  logic              r_halted;
  logic              r_error;
  logic              w_timeout;
  logic              w_exec_entry;

  // A non-HALT word accepted in WAIT_MEM starts a fresh watchdog window
  assign w_exec_entry = (r_state == S_WAIT_MEM) && mem_rvalid && (mem_rdata != HALT_WORD);

  cu_watchdog #(
    .CU_TIMEOUT (CU_TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_exec_entry),
    .i_run     (r_cu_run),
    .o_timeout (w_timeout)
  );

  // Sequencer FSM; every output is registered and set on the transition into its state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_instr  <= '0;
      r_count  <= '0;
      r_mem_rd <= 1'b0;
      r_cu_run <= 1'b0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALTED, S_ERROR: begin
          if (start) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_count  <= '0;
            r_mem_rd <= 1'b1;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
            r_error  <= 1'b0;
          end
        end
        S_FETCH: begin
          r_state  <= S_WAIT_MEM;
          r_mem_rd <= 1'b0;
        end
        S_WAIT_MEM: begin
          if (mem_rvalid) begin
            if (mem_rdata == HALT_WORD) begin
              r_state  <= S_HALTED;
              r_busy   <= 1'b0;
              r_halted <= 1'b1;
            end else begin
              r_state  <= S_EXEC;
              r_instr  <= mem_rdata;
              r_cu_run <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          if (cu_done) begin
            r_state  <= S_GAP;
            r_cu_run <= 1'b0;
            if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
          end else if (w_timeout) begin
            r_state  <= S_ERROR;
            r_cu_run <= 1'b0;
            r_busy   <= 1'b0;
            r_error  <= 1'b1;
          end
        end
        S_GAP: begin
          if (r_pc == LAST_PC) begin
            r_pc     <= '0;
            r_state  <= S_HALTED;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_pc <= r_pc + PC_ONE;
            if (halt_req) begin
              r_state  <= S_HALTED;
              r_busy   <= 1'b0;
              r_halted <= 1'b1;
            end else begin
              r_state  <= S_FETCH;
              r_mem_rd <= 1'b1;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_mem_rd <= 1'b0;
          r_cu_run <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr       = r_pc;
  assign pc             = r_pc;
  assign mem_rd         = r_mem_rd;
  assign cu_instruction = r_instr;
  assign cu_run         = r_cu_run;
  assign instr_count    = r_count;
  assign busy           = r_busy;
  assign halted         = r_halted;
  assign error          = r_error;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: a program memory and a control_unit
// responder surround the DUT; each run is compared against a
// transaction-level model of the program execution.
module tb_instr_fetch_sequencer;

  localparam int          ADDR_W     = 8;
  localparam int          PROG_LEN   = 4;
  localparam int          CU_TIMEOUT = 16;
  localparam logic [15:0] HALT       = 16'hFFFF;

  logic              clk = 1'b0;
  logic              reset, start, halt_req;
  logic [ADDR_W-1:0] mem_addr, pc;
  logic              mem_rd, mem_rvalid, cu_run, cu_done, busy, halted, error;
  logic [15:0]       mem_rdata, cu_instruction, instr_count;

  always #5 clk = ~clk;

  instr_fetch_sequencer #(
    .ADDR_W     (ADDR_W),
    .PROG_LEN   (PROG_LEN),
    .HALT_WORD  (HALT),
    .CU_TIMEOUT (CU_TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .halt_req       (halt_req),
    .mem_addr       (mem_addr),
    .mem_rd         (mem_rd),
    .mem_rdata      (mem_rdata),
    .mem_rvalid     (mem_rvalid),
    .cu_instruction (cu_instruction),
    .cu_run         (cu_run),
    .cu_done        (cu_done),
    .pc             (pc),
    .instr_count    (instr_count),
    .busy           (busy),
    .halted         (halted),
    .error          (error)
  );

  int checks = 0;
  int errors = 0;

  // Scenario configuration, written only by the main sequence
  logic [15:0] prog [PROG_LEN];
  int mem_lat    = 1;
  int done_after = 6;   // run cycle in which done is pulsed; 0 = never
  int halt_at    = 0;   // raise halt_req from this run window on; 0 = never
  int scen       = 0;

  // Observations, written only by the responders
  int fetch_q[$];
  int instr_q[$];
  int win_q[$];
  int gap_q[$];
  int unstable;
  int run_idx;

  int          m_last_scen = 0;
  int          m_pend = 0;
  int          m_wait = 0;
  logic [1:0]  m_addr = '0;
  int          c_last_scen = 0;
  int          c_len = 0;
  int          c_cyc = 0;
  int          c_last_fall = -1;
  logic [15:0] c_held = '0;

  // Program memory: answers each read strobe after mem_lat cycles
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (scen != m_last_scen) begin
        m_last_scen = scen;
        fetch_q.delete();
      end
      mem_rvalid = 1'b0;
      mem_rdata  = 16'($urandom);
      if (reset) begin
        m_pend = 0;
      end else begin
        if (m_pend != 0) begin
          m_wait--;
          if (m_wait == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = prog[m_addr];
            m_pend     = 0;
          end
        end
        if (mem_rd) begin
          fetch_q.push_back(int'(mem_addr));
          m_addr = mem_addr[1:0];
          m_pend = 1;
          m_wait = mem_lat;
        end
      end
    end
  end

  // control_unit stand-in: pulses done in run cycle done_after, records windows and gaps
  initial begin
    cu_done  = 1'b0;
    halt_req = 1'b0;
    unstable = 0;
    run_idx  = 0;
    forever begin
      @(negedge clk);
      c_cyc++;
      if (scen != c_last_scen) begin
        c_last_scen = scen;
        instr_q.delete(); win_q.delete(); gap_q.delete();
        run_idx = 0; c_len = 0; c_last_fall = -1; unstable = 0;
      end
      cu_done = 1'b0;
      if (cu_run) begin
        c_len++;
        if (c_len == 1) begin
          run_idx++;
          instr_q.push_back(int'(cu_instruction));
          c_held = cu_instruction;
          if (c_last_fall >= 0) gap_q.push_back(c_cyc - c_last_fall);
        end else if (cu_instruction !== c_held) begin
          unstable++;
        end
        if (done_after != 0 && c_len == done_after) cu_done = 1'b1;
      end else if (c_len != 0) begin
        win_q.push_back(c_len);
        c_len = 0;
        c_last_fall = c_cyc;
      end
      halt_req = (halt_at != 0) && (run_idx >= halt_at);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " cu_run"}, 32'(cu_run), 0);
    chk({tag, " mem_rd"}, 32'(mem_rd), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " halted"}, 32'(halted), 0);
    chk({tag, " error"}, 32'(error), 0);
    chk({tag, " pc"}, 32'(pc), 0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 0);
    chk({tag, " count"}, 32'(instr_count), 0);
    chk({tag, " instr"}, 32'(cu_instruction), 0);
  endtask

  // One complete program run from a start pulse, checked against the model
  task automatic run_scen(input string tag);
    int e_fetch[$];
    int e_instr[$];
    int e_win[$];
    int p, cnt, k, n;
    bit e_h, e_e;
    scen++;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk({tag, " start mem_rd"}, 32'(mem_rd), 1);
    chk({tag, " start addr"}, 32'(mem_addr), 0);
    chk({tag, " start busy"}, 32'(busy), 1);
    chk({tag, " start error"}, 32'(error), 0);
    chk({tag, " start halted"}, 32'(halted), 0);
    start = 1'b0;
    n = 0;
    while (!(halted || error) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " terminated"}, 32'(halted || error), 1);
    repeat (2) @(negedge clk);

    // Model: walk the program by the sequencing rules
    p = 0; cnt = 0; k = 0; e_h = 0; e_e = 0;
    forever begin
      e_fetch.push_back(p);
      if (prog[p] == HALT) begin e_h = 1; break; end
      e_instr.push_back(int'(prog[p]));
      k++;
      if (done_after == 0 || done_after > CU_TIMEOUT) begin
        e_win.push_back(CU_TIMEOUT); e_e = 1; break;
      end
      e_win.push_back(done_after);
      cnt++;
      if (p == PROG_LEN - 1) begin p = 0; e_h = 1; break; end
      p++;
      if (halt_at != 0 && k >= halt_at) begin e_h = 1; break; end
    end

    chk({tag, " pc"}, 32'(pc), p);
    chk({tag, " count"}, 32'(instr_count), cnt);
    chk({tag, " halted"}, 32'(halted), 32'(e_h));
    chk({tag, " error"}, 32'(error), 32'(e_e));
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " cu_run"}, 32'(cu_run), 0);
    chk({tag, " unstable"}, unstable, 0);
    chk({tag, " n_fetch"}, fetch_q.size(), e_fetch.size());
    for (int i = 0; i < fetch_q.size() && i < e_fetch.size(); i++)
      chk($sformatf("%s fetch%0d", tag, i), fetch_q[i], e_fetch[i]);
    chk({tag, " n_instr"}, instr_q.size(), e_instr.size());
    for (int i = 0; i < instr_q.size() && i < e_instr.size(); i++)
      chk($sformatf("%s instr%0d", tag, i), instr_q[i], e_instr[i]);
    chk({tag, " n_win"}, win_q.size(), e_win.size());
    for (int i = 0; i < win_q.size() && i < e_win.size(); i++)
      chk($sformatf("%s win%0d", tag, i), win_q[i], e_win[i]);
    for (int i = 0; i < gap_q.size(); i++)
      chk($sformatf("%s gap%0d", tag, i), gap_q[i], 2 + mem_lat);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < PROG_LEN; i++) prog[i] = '0;
    @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b0;

    // Three instructions then HALT, latency 1
    prog[0] = 16'h2004; prog[1] = 16'h4408; prog[2] = 16'h600C; prog[3] = HALT;
    mem_lat = 1; done_after = 6; halt_at = 0;
    run_scen("prog_lat1");

    // Same program, slow memory
    mem_lat = 4;
    run_scen("prog_lat4");

    // halt_req raised during the instruction at pc=1
    mem_lat = 1; halt_at = 2;
    run_scen("halt_req");

    // control_unit never answers: watchdog error, then restart
    halt_at = 0; done_after = 0;
    run_scen("timeout");
    done_after = CU_TIMEOUT;
    run_scen("done_at_limit");
    done_after = CU_TIMEOUT + 1;
    run_scen("done_past_limit");

    // No HALT word: runs off the end of the program and wraps pc
    prog[3] = 16'h1234; done_after = 6; mem_lat = 2;
    run_scen("end_of_prog");

    // Asynchronous reset in the middle of an instruction
    scen++;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(cu_run && pc == 1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midexec reached", 32'(cu_run && pc == 1), 1);
    @(negedge clk);
    chk("midexec count", 32'(instr_count), 1);
    #1 reset = 1'b1;
    #1 chk_idle_outputs("midexec reset");
    @(negedge clk);
    reset = 1'b0;
    run_scen("after_reset");

    // Randomised programs, latencies, done timing and halt requests
    for (int s = 0; s < 24; s++) begin
      for (int i = 0; i < PROG_LEN; i++)
        prog[i] = ($urandom_range(0, 5) == 0) ? HALT : 16'($urandom_range(0, 16'hFFFE));
      mem_lat    = $urandom_range(1, 5);
      done_after = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, CU_TIMEOUT + 1);
      halt_at    = $urandom_range(0, 4);
      run_scen($sformatf("rand%0d", s));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
